// File: rtl/encoder4to2_al_sync.sv
// Registered, debounced 4-to-2 priority encoder for active-low request lines.
// Codes are presented one per press on a valid/ready handshake.
module encoder4to2_al_sync #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] y_n,
    input  logic       ready,
    output logic [1:0] w,
    output logic       valid,
    output logic       multi,
    output logic       ovf,
    output logic       idle
);

    typedef enum logic {S_IDLE, S_HELD} state_t;

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [3:0]       NONE     = 4'b1111;

    logic [3:0]       s1_q, s1_d, s2_q, s2_d;
    logic [3:0]       cand_q, cand_d, stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [1:0]       last_code_q, last_code_d;
    logic             ev_q, ev_d;
    logic [1:0]       ev_code_q, ev_code_d;
    logic             ev_multi_q, ev_multi_d;
    logic [1:0]       w_q, w_d;
    logic             valid_q, valid_d;
    logic             multi_q, multi_d;
    logic             ovf_q, ovf_d;
    logic             idle_q, idle_d;

    function automatic logic [1:0] enc(input logic [3:0] p);
        if (!p[3])      return 2'b11;
        else if (!p[2]) return 2'b10;
        else if (!p[1]) return 2'b01;
        else            return 2'b00;
    endfunction

    function automatic logic many_low(input logic [3:0] p);
        return ($countones(~p) >= 2);
    endfunction

    always_comb begin
        s1_d     = y_n;
        s2_d     = s1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else begin
            if (cnt_q < DEB_MAX)
                cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == DEB_LAST)
                stable_d = cand_q;
        end
    end

    // The FSM looks at the pattern being committed this edge, so the event
    // flop and idle update together with stable; the output stage acts a cycle later.
    always_comb begin
        state_d     = state_q;
        last_code_d = last_code_q;
        ev_d        = 1'b0;
        ev_code_d   = ev_code_q;
        ev_multi_d  = ev_multi_q;
        idle_d      = (stable_d == NONE);
        case (state_q)
            S_IDLE: begin
                if (stable_d != NONE) begin
                    state_d     = S_HELD;
                    ev_d        = 1'b1;
                    ev_code_d   = enc(stable_d);
                    ev_multi_d  = many_low(stable_d);
                    last_code_d = enc(stable_d);
                end
            end
            S_HELD: begin
                if (stable_d == NONE) begin
                    state_d = S_IDLE;
                end else if (enc(stable_d) != last_code_q) begin
                    ev_d        = 1'b1;
                    ev_code_d   = enc(stable_d);
                    ev_multi_d  = many_low(stable_d);
                    last_code_d = enc(stable_d);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_d     = w_q;
        multi_d = multi_q;
        valid_d = valid_q;
        ovf_d   = ev_q && valid_q && !ready;
        if (ev_q && (!valid_q || ready)) begin
            w_d     = ev_code_q;
            multi_d = ev_multi_q;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Release of rst_n is expected to be synchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= NONE;
            s2_q        <= NONE;
            cand_q      <= NONE;
            stable_q    <= NONE;
            cnt_q       <= '0;
            state_q     <= S_IDLE;
            last_code_q <= 2'b00;
            ev_q        <= 1'b0;
            ev_code_q   <= 2'b00;
            ev_multi_q  <= 1'b0;
            w_q         <= 2'b00;
            valid_q     <= 1'b0;
            multi_q     <= 1'b0;
            ovf_q       <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            last_code_q <= last_code_d;
            ev_q        <= ev_d;
            ev_code_q   <= ev_code_d;
            ev_multi_q  <= ev_multi_d;
            w_q         <= w_d;
            valid_q     <= valid_d;
            multi_q     <= multi_d;
            ovf_q       <= ovf_d;
            idle_q      <= idle_d;
        end
    end

    assign w     = w_q;
    assign valid = valid_q;
    assign multi = multi_q;
    assign ovf   = ovf_q;
    assign idle  = idle_q;

endmodule

// File: tb/tb_encoder4to2_al_sync.sv
// Scenario bench for encoder4to2_al_sync: each task drives one behaviour and
// checks it inline; a scoreboard checks every code consumed by a handshake.
module tb_encoder4to2_al_sync;

    typedef struct packed {
        logic [1:0] w;
        logic       m;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] y_n;
    logic       ready;
    logic [1:0] w;
    logic       valid, multi, ovf, idle;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    encoder4to2_al_sync #(.DEB_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .y_n(y_n), .ready(ready),
        .w(w), .valid(valid), .multi(multi), .ovf(ovf), .idle(idle)
    );

    always #5 clk = ~clk;

    // Every handshake consumes the oldest expected code.
    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (rst_n && valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: got w=%b multi=%b, required no pending code", w, multi);
            end else begin
                e = exp_q.pop_front();
                if ({w, multi} !== {e.w, e.m}) begin
                    errors++;
                    $display("[TB] FAIL sb_code: got w=%b multi=%b, required w=%b multi=%b", w, multi, e.w, e.m);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        y_n   = 4'b1111;
        ready = 1'b1;
        step(3);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b required 0", valid); end
        checks++; if (w !== 2'b00)    begin errors++; $display("[TB] FAIL rst_w: got %b required 00", w); end
        checks++; if (multi !== 1'b0) begin errors++; $display("[TB] FAIL rst_multi: got %b required 0", multi); end
        checks++; if (ovf !== 1'b0)   begin errors++; $display("[TB] FAIL rst_ovf: got %b required 0", ovf); end
        checks++; if (idle !== 1'b1)  begin errors++; $display("[TB] FAIL rst_idle: got %b required 1", idle); end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_latency();
        y_n = 4'b1011;
        exp_q.push_back('{w: 2'b10, m: 1'b0});
        for (int k = 1; k <= 12; k++) begin
            step(1);
            checks++;
            if (valid !== logic'(k == 8)) begin
                errors++; $display("[TB] FAIL lat_valid edge %0d: got %b required %b", k, valid, (k == 8));
            end
            checks++;
            if (idle !== logic'(k < 7)) begin
                errors++; $display("[TB] FAIL lat_idle edge %0d: got %b required %b", k, idle, (k < 7));
            end
            if (k == 8) begin
                checks++;
                if (w !== 2'b10) begin errors++; $display("[TB] FAIL lat_w: got %b required 10", w); end
            end
        end
        y_n = 4'b1111;
        step(10);
        checks++; if (idle !== 1'b1)  begin errors++; $display("[TB] FAIL rel_idle: got %b required 1", idle); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL rel_valid: got %b required 0", valid); end
    endtask

    task automatic test_glitch();
        y_n = 4'b1110;
        for (int k = 1; k <= 18; k++) begin
            if (k == 4) y_n = 4'b1111;
            step(1);
            checks++;
            if ({valid, idle, w} !== 4'b0110) begin
                errors++;
                $display("[TB] FAIL glitch edge %0d: got valid=%b idle=%b w=%b required valid=0 idle=1 w=10", k, valid, idle, w);
            end
        end
    endtask

    task automatic test_overflow();
        ready = 1'b0;
        y_n   = 4'b1101;
        exp_q.push_back('{w: 2'b01, m: 1'b0});
        step(12);
        checks++;
        if ({valid, w, multi} !== 4'b1010) begin
            errors++; $display("[TB] FAIL ovf_first: got valid=%b w=%b multi=%b required 1 01 0", valid, w, multi);
        end
        y_n = 4'b1111;
        step(10);
        y_n = 4'b0111;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            checks++;
            if (ovf !== logic'(k == 8)) begin
                errors++; $display("[TB] FAIL ovf_pulse edge %0d: got %b required %b", k, ovf, (k == 8));
            end
            checks++;
            if ({valid, w} !== 3'b101) begin
                errors++; $display("[TB] FAIL ovf_hold edge %0d: got valid=%b w=%b required 1 01", k, valid, w);
            end
        end
        ready = 1'b1;
        step(1);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drain: got %b required 0", valid); end
        y_n = 4'b1111;
        step(10);
    endtask

    task automatic test_multi();
        int n;
        ready = 1'b1;
        y_n   = 4'b0110;
        exp_q.push_back('{w: 2'b11, m: 1'b1});
        n = 0;
        for (int k = 1; k <= 12; k++) begin step(1); if (valid === 1'b1) n++; end
        checks++; if (n != 1) begin errors++; $display("[TB] FAIL multi_press: got %0d valid cycles required 1", n); end
        y_n = 4'b0111;
        n = 0;
        for (int k = 1; k <= 12; k++) begin step(1); if (valid === 1'b1) n++; end
        checks++; if (n != 0) begin errors++; $display("[TB] FAIL same_code: got %0d valid cycles required 0", n); end
        y_n = 4'b1110;
        exp_q.push_back('{w: 2'b00, m: 1'b0});
        n = 0;
        for (int k = 1; k <= 12; k++) begin step(1); if (valid === 1'b1) n++; end
        checks++; if (n != 1) begin errors++; $display("[TB] FAIL new_code: got %0d valid cycles required 1", n); end
        checks++;
        if ({w, multi} !== 3'b000) begin
            errors++; $display("[TB] FAIL new_code_hold: got w=%b multi=%b required 00 0", w, multi);
        end
        y_n = 4'b1111;
        step(10);
    endtask

    task automatic test_back_to_back();
        ready = 1'b0;
        y_n   = 4'b1101;
        exp_q.push_back('{w: 2'b01, m: 1'b0});
        step(12);
        checks++;
        if ({valid, w} !== 3'b101) begin
            errors++; $display("[TB] FAIL b2b_first: got valid=%b w=%b required 1 01", valid, w);
        end
        y_n = 4'b1011;
        exp_q.push_back('{w: 2'b10, m: 1'b0});
        for (int k = 1; k <= 7; k++) begin
            step(1);
            checks++;
            if ({valid, w, ovf} !== 4'b1010) begin
                errors++; $display("[TB] FAIL b2b_wait edge %0d: got valid=%b w=%b ovf=%b required 1 01 0", k, valid, w, ovf);
            end
        end
        ready = 1'b1;
        step(1);
        checks++;
        if ({valid, w, ovf} !== 4'b1100) begin
            errors++; $display("[TB] FAIL b2b_swap: got valid=%b w=%b ovf=%b required 1 10 0", valid, w, ovf);
        end
        step(1);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b required 0", valid); end
        y_n = 4'b1111;
        step(10);
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        y_n   = 4'b0101;
        exp_q.push_back('{w: 2'b11, m: 1'b1});
        step(12);
        checks++;
        if ({valid, w, multi} !== 4'b1111) begin
            errors++; $display("[TB] FAIL mid_pending: got valid=%b w=%b multi=%b required 1 11 1", valid, w, multi);
        end
        y_n = 4'b1101;
        step(3);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({valid, ovf, multi, idle, w} !== 6'b000100) begin
            errors++; $display("[TB] FAIL mid_async: got valid=%b ovf=%b multi=%b idle=%b w=%b required 0 0 0 1 00", valid, ovf, multi, idle, w);
        end
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        ready = 1'b1;
        exp_q.push_back('{w: 2'b01, m: 1'b0});
        for (int k = 1; k <= 12; k++) begin
            step(1);
            checks++;
            if (valid !== logic'(k == 8)) begin
                errors++; $display("[TB] FAIL mid_relatch edge %0d: got %b required %b", k, valid, (k == 8));
            end
            if (k == 8) begin
                checks++;
                if (w !== 2'b01) begin errors++; $display("[TB] FAIL mid_w: got %b required 01", w); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_overflow();
        test_multi();
        test_back_to_back();
        test_reset_mid();
        step(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("[TB] FAIL sb_leftover: got %0d pending codes required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
